// File: rtl/uart_pkg.sv
// Shared UART package: FIFO FSM state encoding and default widths/depths.
// Used by the TX FIFO today and intended for the RX FIFO as well.
package uart_pkg;

    localparam int UART_DATA_BITS_DEFAULT     = 8;
    localparam int UART_TX_FIFO_DEPTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } tx_fifo_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// FIFO storage array: DEPTH x DATA_BITS registers, synchronous write,
// asynchronous read by address. Contents are never reset.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS_DEFAULT,
    parameter int DEPTH      = UART_TX_FIFO_DEPTH_DEFAULT,
    localparam int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 wr_en_in,
    input  logic [ADDR_BITS-1:0] wr_addr_in,
    input  logic [DATA_BITS-1:0] wr_data_in,
    input  logic [ADDR_BITS-1:0] rd_addr_in,
    output logic [DATA_BITS-1:0] rd_data_out
);

    logic [DATA_BITS-1:0] mem_q [DEPTH];

    // Store the incoming byte at the write address.
    always_ff @(posedge clk) begin
        if (wr_en_in) begin
            mem_q[wr_addr_in] <= wr_data_in;
        end
    end

    assign rd_data_out = mem_q[rd_addr_in];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the uart transmitter one byte at a time through the
// data_rdy / tx_data / tx_done handshake. Writes are single-cycle strobes.
// Optional build macro UART_TX_FIFO_OVF_STICKY_EN adds a sticky overflow
// flag (overflow_out) with a clear input (clr_ovf_in).
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS_DEFAULT,
    parameter int DEPTH      = UART_TX_FIFO_DEPTH_DEFAULT,
    localparam int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 nrst_in,
`ifdef UART_TX_FIFO_OVF_STICKY_EN
    input  logic                 clr_ovf_in,
    output logic                 overflow_out,
`endif
    input  logic                 wr_en_in,
    input  logic [DATA_BITS-1:0] wr_data_in,
    output logic                 full_out,
    output logic                 empty_out,
    output logic [ADDR_BITS:0]   count_out,
    output logic                 uart_data_rdy_out,
    output logic [DATA_BITS-1:0] uart_tx_data_out,
    input  logic                 uart_tx_done_in
);

    localparam int CNT_BITS = ADDR_BITS + 1;

    tx_fifo_state_t       state_q, state_d;
    logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0]  count_q, count_d;
    logic                 full_q, full_d;
    logic                 empty_q, empty_d;
    logic                 rdy_q, rdy_d;
    logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
    logic [DATA_BITS-1:0] rd_data;
    logic                 pop;
    logic                 wr_accept;

    uart_fifo_mem #(
        .DATA_BITS (DATA_BITS),
        .DEPTH     (DEPTH)
    ) u_mem (
        .clk         (clk),
        .wr_en_in    (wr_accept),
        .wr_addr_in  (wr_ptr_q),
        .wr_data_in  (wr_data_in),
        .rd_addr_in  (rd_ptr_q),
        .rd_data_out (rd_data)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!nrst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: fetch when data is queued, wait for the uart, idle one gap cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (count_q != '0) state_d = SEND;
            SEND:    if (uart_tx_done_in) state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: pop on completion, ready only while a byte is being offered, latch byte on fetch.
    always_comb begin
        pop       = (state_q == SEND) && uart_tx_done_in;
        rdy_d     = (state_q == SEND) && !uart_tx_done_in;
        tx_data_d = tx_data_q;
        if ((state_q == IDLE) && (count_q != '0)) begin
            tx_data_d = rd_data;
        end
    end

    // Occupancy bookkeeping; a write while full is only taken if a pop frees the slot this cycle.
    always_comb begin
        wr_accept = wr_en_in && (!full_q || pop);
        wr_ptr_d  = wr_accept ? wr_ptr_q + ADDR_BITS'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + ADDR_BITS'(1) : rd_ptr_q;
        count_d   = count_q + CNT_BITS'(wr_accept) - CNT_BITS'(pop);
        full_d    = (count_d == CNT_BITS'(DEPTH));
        empty_d   = (count_d == '0);
    end

    // Pointer, count, flag and uart-side output registers.
    always_ff @(posedge clk) begin
        if (!nrst_in) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            rdy_q     <= 1'b0;
            tx_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            rdy_q     <= rdy_d;
            tx_data_q <= tx_data_d;
        end
    end

`ifdef UART_TX_FIFO_OVF_STICKY_EN
    logic ovf_q, ovf_d;
    logic drop;

    // Sticky overflow: a dropped write sets it and wins over a same-cycle clear.
    always_comb begin
        drop  = wr_en_in && full_q && !pop;
        ovf_d = ovf_q;
        if (clr_ovf_in) ovf_d = 1'b0;
        if (drop)       ovf_d = 1'b1;
    end

    // Overflow flag register.
    always_ff @(posedge clk) begin
        if (!nrst_in) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow_out = ovf_q;
`endif

    assign full_out          = full_q;
    assign empty_out         = empty_q;
    assign count_out         = count_q;
    assign uart_data_rdy_out = rdy_q;
    assign uart_tx_data_out  = tx_data_q;

endmodule
